// File: rtl/prefetch_queue_if.sv
// Prefetch queue bus bundle: memory read port, jump/flush input and the
// instruction-word consumer port. The master modport is the queue itself,
// the slave modport is the environment (memory, sequencer, consumer).
interface prefetch_queue_if;
  logic        flush;
  logic [22:0] pc;
  logic        progreq;
  logic [21:0] progaddr;
  logic        progack;
  logic [31:0] progdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_take;
  logic [2:0]  qs_n;

  modport master (
    input  flush, pc, progack, progdata, instr_take,
    output progreq, progaddr, instr, instr_valid, qs_n
  );

  modport slave (
    output flush, pc, progack, progdata, instr_take,
    input  progreq, progaddr, instr, instr_valid, qs_n
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches big-endian longwords from program
// memory and hands out 16-bit instruction words in FIFO order (up to 6).
// A flush restarts fetching at a new word address; an odd word address
// sets the skip flag so only the low half of the first longword is kept.
// Optional feature macro: PREFETCH_BYPASS_EN -- when defined, the first word
// of a longword arriving into an empty queue is presented combinationally.
module prefetch_queue #(
  parameter logic [22:0] RESET_PC = 23'h7F8004
) (
  input  logic           i_sys_clk,
  input  logic           i_reset,
  prefetch_queue_if.master io_bus
);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_started;
  logic [2:0]  r_count;
  logic [2:0]  w_nextCount;
  logic [21:0] r_ptr;
  logic [21:0] r_addr;
  logic        r_skip;
  logic [15:0] r_q [6];
  logic [15:0] w_nextQ [6];

  logic        w_accept;
  logic        w_take;
  logic        w_valid;
  logic [15:0] w_instr;
  logic [15:0] w_word0;
  logic [15:0] w_word1;
  logic [1:0]  w_nwr;
  logic [3:0]  w_srcIdx;
  logic [3:0]  w_newIdx;

  // An ack only counts when we are really waiting for it and no jump overrides it.
  assign w_accept = io_bus.progack && (r_state == REQ) && !io_bus.flush;
  assign w_word0  = r_skip ? io_bus.progdata[15:0] : io_bus.progdata[31:16];
  assign w_word1  = io_bus.progdata[15:0];
  assign w_nwr    = w_accept ? (r_skip ? 2'd1 : 2'd2) : 2'd0;

`ifdef PREFETCH_BYPASS_EN
  assign w_valid = (r_count != 3'd0) || w_accept;
  assign w_instr = ((r_count == 3'd0) && w_accept) ? w_word0 : r_q[0];
`else
  assign w_valid = (r_count != 3'd0);
  assign w_instr = r_q[0];
`endif

  assign w_take = io_bus.instr_take && w_valid;

  assign io_bus.progreq     = (r_state != IDLE);
  assign io_bus.progaddr    = r_addr;
  assign io_bus.instr       = w_instr;
  assign io_bus.instr_valid = w_valid;
  assign io_bus.qs_n        = ~r_count;

  // Next fetch state: request whenever there is room for a full longword.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (r_started && !io_bus.flush && (r_count <= 3'd4)) w_nextState = REQ;
      REQ:     if (io_bus.progack) w_nextState = IDLE;
               else if (io_bus.flush) w_nextState = DISCARD;
      DISCARD: if (io_bus.progack) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register; r_started holds off the first request one cycle after reset release.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_started <= 1'b1;
    end
  end

  // Word count after this cycle's writes and pop; a flush empties the queue.
  always_comb begin
    w_nextCount = r_count + {1'b0, w_nwr} - {2'b00, w_take};
    if (io_bus.flush) w_nextCount = 3'd0;
  end

  // Next queue image: surviving old words shifted down, then the new words.
  always_comb begin
    w_srcIdx = 4'd0;
    w_newIdx = 4'd0;
    for (int i = 0; i < 6; i++) begin
      w_srcIdx   = 4'(i) + {3'b000, w_take};
      w_newIdx   = w_srcIdx - {1'b0, r_count};
      w_nextQ[i] = r_q[i];
      if (w_srcIdx < {1'b0, r_count})
        w_nextQ[i] = r_q[w_srcIdx[2:0]];
      else if ((w_newIdx == 4'd0) && (w_nwr != 2'd0))
        w_nextQ[i] = w_word0;
      else if ((w_newIdx == 4'd1) && (w_nwr == 2'd2))
        w_nextQ[i] = w_word1;
    end
  end

  // Queue storage, fetch pointer, skip flag and the request address latched at issue.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= 3'd0;
      r_ptr   <= RESET_PC[22:1];
      r_skip  <= RESET_PC[0];
      r_addr  <= RESET_PC[22:1];
      for (int i = 0; i < 6; i++) r_q[i] <= 16'h0000;
    end else begin
      r_count <= w_nextCount;
      for (int i = 0; i < 6; i++) r_q[i] <= w_nextQ[i];
      if (io_bus.flush) begin
        r_ptr  <= io_bus.pc[22:1];
        r_skip <= io_bus.pc[0];
      end else if (w_accept) begin
        r_ptr  <= r_ptr + 22'd1;
        r_skip <= 1'b0;
      end
      if ((r_state == IDLE) && (w_nextState == REQ)) r_addr <= r_ptr;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed testbench for prefetch_queue: reset values, queue fill and drain,
// simultaneous take/ack, skip on odd jump targets, flush during a request,
// pointer wrap and reset in the middle of a request.
module tb_prefetch_queue;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  prefetch_queue_if bus ();

  prefetch_queue #(.RESET_PC(23'h7F8004)) dut (
    .i_sys_clk (clock),
    .i_reset   (reset),
    .io_bus    (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, then return inputs to idle.
  task automatic applyStimulus(input logic flushIn, input logic [22:0] pcIn, input logic ackIn,
                               input logic [31:0] dataIn, input logic takeIn);
    bus.flush      = flushIn;
    bus.pc         = pcIn;
    bus.progack    = ackIn;
    bus.progdata   = dataIn;
    bus.instr_take = takeIn;
    @(posedge clock);
    #1;
    bus.flush      = 1'b0;
    bus.progack    = 1'b0;
    bus.instr_take = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 23'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic waitRequest(input string tag);
    int n = 0;
    while (bus.progreq !== 1'b1 && n < 20) begin
      idleCycle();
      n++;
    end
    checkOutput({tag, "_req"}, 32'(bus.progreq), 32'h1);
  endtask

  // Memory model: answer the pending request two cycles after it is seen.
  task automatic serveRequest(input string tag, input logic [21:0] expAddr, input logic [31:0] data,
                              input bit emptyBefore, input logic [15:0] firstWord, input logic takeIn);
    waitRequest(tag);
    checkOutput({tag, "_addr"}, 32'(bus.progaddr), 32'(expAddr));
    idleCycle();
    checkOutput({tag, "_addrStable"}, 32'(bus.progaddr), 32'(expAddr));
    bus.progack    = 1'b1;
    bus.progdata   = data;
    bus.instr_take = takeIn;
    #1;
    if (emptyBefore) begin
`ifdef PREFETCH_BYPASS_EN
      checkOutput({tag, "_bypassValid"}, 32'(bus.instr_valid), 32'h1);
      checkOutput({tag, "_bypassInstr"}, 32'(bus.instr), 32'(firstWord));
`else
      checkOutput({tag, "_ackCycleValid"}, 32'(bus.instr_valid), 32'h0);
`endif
    end
    @(posedge clock);
    #1;
    bus.progack    = 1'b0;
    bus.instr_take = 1'b0;
    checkOutput({tag, "_reqDrop"}, 32'(bus.progreq), 32'h0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.pc         = 23'h0;
    bus.progack    = 1'b0;
    bus.progdata   = 32'h0;
    bus.instr_take = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_progreq", 32'(bus.progreq), 32'h0);
    checkOutput("rst_valid", 32'(bus.instr_valid), 32'h0);
    checkOutput("rst_qsn", 32'(bus.qs_n), 32'h7);
    checkOutput("rst_instr", 32'(bus.instr), 32'h0);
    checkOutput("rst_addr", 32'(bus.progaddr), 32'h3FC002);

    // Release away from the edge; request appears on the second edge.
    reset = 1'b0;
    idleCycle();
    checkOutput("rel1_progreq", 32'(bus.progreq), 32'h0);
    idleCycle();
    checkOutput("rel2_progreq", 32'(bus.progreq), 32'h1);

    // Fill the queue to six words.
    serveRequest("fill1", 22'h3FC002, 32'h1234ABCD, 1'b1, 16'h1234, 1'b0);
    checkOutput("fill1_qsn", 32'(bus.qs_n), 32'h5);
    checkOutput("fill1_valid", 32'(bus.instr_valid), 32'h1);
    checkOutput("fill1_instr", 32'(bus.instr), 32'h1234);
    serveRequest("fill2", 22'h3FC003, 32'h11112222, 1'b0, 16'h0, 1'b0);
    checkOutput("fill2_qsn", 32'(bus.qs_n), 32'h3);
    serveRequest("fill3", 22'h3FC004, 32'h33334444, 1'b0, 16'h0, 1'b0);
    checkOutput("fill3_qsn", 32'(bus.qs_n), 32'h1);
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      checkOutput("full_noReq", 32'(bus.progreq), 32'h0);
    end

    // Drain in FIFO order.
    applyStimulus(1'b0, 23'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("take1_instr", 32'(bus.instr), 32'hABCD);
    checkOutput("take1_qsn", 32'(bus.qs_n), 32'h2);
    applyStimulus(1'b0, 23'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("take2_instr", 32'(bus.instr), 32'h1111);
    checkOutput("take2_qsn", 32'(bus.qs_n), 32'h3);

    // Take and ack in the same cycle: 4 + 2 - 1 = 5, no request above 4.
    serveRequest("takeAck", 22'h3FC005, 32'h55556666, 1'b0, 16'h0, 1'b1);
    checkOutput("takeAck_qsn", 32'(bus.qs_n), 32'h2);
    checkOutput("takeAck_instr", 32'(bus.instr), 32'h2222);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("five_noReq", 32'(bus.progreq), 32'h0);
    end
    applyStimulus(1'b0, 23'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("take3_instr", 32'(bus.instr), 32'h3333);
    serveRequest("refill", 22'h3FC006, 32'h77778888, 1'b0, 16'h0, 1'b0);
    checkOutput("refill_qsn", 32'(bus.qs_n), 32'h1);

    // Jump to an odd word address: only the low half of the first longword.
    applyStimulus(1'b1, 23'h000101, 1'b0, 32'h0, 1'b1);
    checkOutput("flush_valid", 32'(bus.instr_valid), 32'h0);
    checkOutput("flush_qsn", 32'(bus.qs_n), 32'h7);
    serveRequest("skip", 22'h000080, 32'hDEADBEEF, 1'b1, 16'hBEEF, 1'b0);
    checkOutput("skip_qsn", 32'(bus.qs_n), 32'h6);
    checkOutput("skip_instr", 32'(bus.instr), 32'hBEEF);

    // Flush while a request is outstanding: its data must be dropped.
    waitRequest("disc");
    checkOutput("disc_addr", 32'(bus.progaddr), 32'h000081);
    applyStimulus(1'b1, 23'h200010, 1'b0, 32'h0, 1'b0);
    checkOutput("disc_progreq", 32'(bus.progreq), 32'h1);
    checkOutput("disc_addrHeld", 32'(bus.progaddr), 32'h000081);
    checkOutput("disc_qsn", 32'(bus.qs_n), 32'h7);
    idleCycle();
    idleCycle();
    checkOutput("disc_stillReq", 32'(bus.progreq), 32'h1);
    applyStimulus(1'b0, 23'h0, 1'b1, 32'hCAFEF00D, 1'b0);
    checkOutput("discAck_progreq", 32'(bus.progreq), 32'h0);
    checkOutput("discAck_qsn", 32'(bus.qs_n), 32'h7);
    checkOutput("discAck_valid", 32'(bus.instr_valid), 32'h0);
    serveRequest("newPc", 22'h100008, 32'h13579BDF, 1'b1, 16'h1357, 1'b0);
    checkOutput("newPc_instr", 32'(bus.instr), 32'h1357);
    checkOutput("newPc_qsn", 32'(bus.qs_n), 32'h5);

    // Fetch pointer wrap from the top of the address space.
    applyStimulus(1'b1, 23'h7FFFFE, 1'b0, 32'h0, 1'b0);
    checkOutput("wrapFlush_qsn", 32'(bus.qs_n), 32'h7);
    serveRequest("wrapHi", 22'h3FFFFF, 32'h0A0B0C0D, 1'b1, 16'h0A0B, 1'b0);
    checkOutput("wrapHi_instr", 32'(bus.instr), 32'h0A0B);
    serveRequest("wrapLo", 22'h000000, 32'h01020304, 1'b0, 16'h0, 1'b0);
    checkOutput("wrapLo_qsn", 32'(bus.qs_n), 32'h3);

    // Reset in the middle of a request; a late ack must be ignored.
    waitRequest("rstReq");
    #2 reset = 1'b1;
    #1;
    checkOutput("midRst_progreq", 32'(bus.progreq), 32'h0);
    checkOutput("midRst_qsn", 32'(bus.qs_n), 32'h7);
    checkOutput("midRst_valid", 32'(bus.instr_valid), 32'h0);
    checkOutput("midRst_instr", 32'(bus.instr), 32'h0);
    checkOutput("midRst_addr", 32'(bus.progaddr), 32'h3FC002);
    #2 reset = 1'b0;
    applyStimulus(1'b0, 23'h0, 1'b1, 32'hFFFF0000, 1'b0);
    checkOutput("lateAck_qsn", 32'(bus.qs_n), 32'h7);
    checkOutput("lateAck_valid", 32'(bus.instr_valid), 32'h0);
    checkOutput("lateAck_progreq", 32'(bus.progreq), 32'h0);
    idleCycle();
    checkOutput("restart_progreq", 32'(bus.progreq), 32'h1);
    checkOutput("restart_addr", 32'(bus.progaddr), 32'h3FC002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
